// File: rtl/mem_bus_arbiter_if.sv
// Native memory bus (picorv32 style): valid/instr/addr/wdata/wstrb request, ready/rdata response.
// The request side uses the master modport, the responding side uses the slave modport.
interface mem_bus_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master native-bus arbiter with registered slave request and watchdog error completion.
// Define MEM_BUS_ARB_RR_EN for round-robin ties; otherwise master 1 has fixed priority.
module mem_bus_arbiter #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    mem_bus_arbiter_if.master s,
    output logic [1:0]       grant,
    output logic             timeout_err
);

    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wdog;
    logic            s_valid_q, s_instr_q;
    logic [31:0]     s_addr_q, s_wdata_q;
    logic [3:0]      s_wstrb_q;
    logic            any_req, pick_m1, done, tmo, take;
    logic [31:0]     rsp_data;

    assign any_req = m0.valid | m1.valid;
    assign take    = (state == IDLE) && any_req;

`ifdef MEM_BUS_ARB_RR_EN
    // last_m1 resets high so master 0 wins the first tie.
    logic last_m1;
    assign pick_m1 = m1.valid & (~m0.valid | ~last_m1);

    always_ff @(posedge clk) begin
        if (reset)     last_m1 <= 1'b1;
        else if (take) last_m1 <= pick_m1;
    end
`else
    assign pick_m1 = m1.valid;
`endif

    // Slave completion wins over a watchdog expiry in the same cycle.
    assign done     = (state == BUSY) && s.ready;
    assign tmo      = (state == BUSY) && !s.ready && WD_EN && (wdog == WD_LIMIT);
    assign rsp_data = done ? s.rdata : ERR_RDATA;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req)     state_nxt = BUSY;
            BUSY: if (done || tmo) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m0.ready = 1'b0;
        m1.ready = 1'b0;
        m0.rdata = '0;
        m1.rdata = '0;
        if (!reset && (done || tmo)) begin
            if (grant[0]) begin
                m0.ready = 1'b1;
                m0.rdata = rsp_data;
            end
            if (grant[1]) begin
                m1.ready = 1'b1;
                m1.rdata = rsp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid_q   <= 1'b0;
            s_instr_q   <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wstrb_q   <= '0;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
            wdog        <= '0;
        end else if (take) begin
            s_valid_q <= 1'b1;
            s_instr_q <= pick_m1 ? m1.instr : m0.instr;
            s_addr_q  <= pick_m1 ? m1.addr  : m0.addr;
            s_wdata_q <= pick_m1 ? m1.wdata : m0.wdata;
            s_wstrb_q <= pick_m1 ? m1.wstrb : m0.wstrb;
            grant     <= pick_m1 ? 2'b10 : 2'b01;
            wdog      <= '0;
        end else if (done || tmo) begin
            s_valid_q <= 1'b0;
            grant     <= 2'b00;
            if (tmo) timeout_err <= 1'b1;
        end else if (state == BUSY && wdog != '1) begin
            wdog <= wdog + WD_W'(1);
        end
    end

    assign s.valid = s_valid_q;
    assign s.instr = s_instr_q;
    assign s.addr  = s_addr_q;
    assign s.wdata = s_wdata_q;
    assign s.wstrb = s_wstrb_q;

endmodule
